// File: rtl/instr_mem_loader_if.sv
// Loader bus: symbolic instruction stream in, instruction-memory write port out.
// Stream handshake: a field set transfers on a rising edge where in_valid && in_ready;
// in_ready never depends on in_valid, and the host holds fields stable while in_valid is high.
interface instr_mem_loader_if;
  logic        in_valid;
  logic        in_ready;
  logic        in_last;
  logic [3:0]  op_sel;
  logic [4:0]  rs;
  logic [4:0]  rt;
  logic [4:0]  rd;
  logic [15:0] imm;
  logic [25:0] target;
  logic        mem_we;
  logic [31:0] mem_addr;
  logic [31:0] mem_wdata;

  modport master (
    output in_valid, in_last, op_sel, rs, rt, rd, imm, target,
    input  in_ready, mem_we, mem_addr, mem_wdata
  );

  modport slave (
    input  in_valid, in_last, op_sel, rs, rt, rd, imm, target,
    output in_ready, mem_we, mem_addr, mem_wdata
  );
endinterface

// File: rtl/instr_mem_loader.sv
// Encodes symbolic MIPS instructions into 32-bit words and writes them to instruction
// memory at consecutive byte addresses, holding the CPU in reset until the load completes.
module instr_mem_loader #(
    parameter logic [31:0] BASE_ADDR = 32'h0000_0000,
    parameter int          MAX_WORDS = 256
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                start,
    instr_mem_loader_if.slave   bus,
    output logic                cpu_hold,
    output logic                done,
    output logic                err,
    output logic                overflow,
    output logic [15:0]         word_count,
    output logic [1:0]          state_dbg
);

    localparam logic [1:0] S_IDLE = 2'd0;
    localparam logic [1:0] S_LOAD = 2'd1;
    localparam logic [1:0] S_DONE = 2'd2;

    localparam logic [3:0] OP_ADD  = 4'd0;
    localparam logic [3:0] OP_SUB  = 4'd1;
    localparam logic [3:0] OP_AND  = 4'd2;
    localparam logic [3:0] OP_OR   = 4'd3;
    localparam logic [3:0] OP_SLT  = 4'd4;
    localparam logic [3:0] OP_LW   = 4'd5;
    localparam logic [3:0] OP_SW   = 4'd6;
    localparam logic [3:0] OP_BEQ  = 4'd7;
    localparam logic [3:0] OP_ADDI = 4'd8;
    localparam logic [3:0] OP_J    = 4'd9;
    localparam logic [3:0] OP_JAL  = 4'd10;
    localparam logic [3:0] OP_JR   = 4'd11;
    localparam logic [3:0] OP_SLTI = 4'd12;

    // Opcode/funct set matches the core's control decoder, including its JR and ADDI codes.
    localparam logic [5:0] F_ADD   = 6'b100000;
    localparam logic [5:0] F_SUB   = 6'b100011;
    localparam logic [5:0] F_AND   = 6'b100100;
    localparam logic [5:0] F_OR    = 6'b100101;
    localparam logic [5:0] F_SLT   = 6'b101010;
    localparam logic [5:0] OPC_LW   = 6'b100011;
    localparam logic [5:0] OPC_SW   = 6'b101011;
    localparam logic [5:0] OPC_BEQ  = 6'b000100;
    localparam logic [5:0] OPC_ADDI = 6'b001001;
    localparam logic [5:0] OPC_SLTI = 6'b001010;
    localparam logic [5:0] OPC_J    = 6'b000010;
    localparam logic [5:0] OPC_JAL  = 6'b000011;
    localparam logic [5:0] OPC_JR   = 6'b000110;

    localparam logic [15:0] MAX_CNT = 16'(MAX_WORDS);

    logic [1:0]  state;
    logic [31:0] wptr;
    logic        mem_we_q;
    logic [31:0] mem_addr_q;
    logic [31:0] mem_wdata_q;
    logic        cpu_hold_q;
    logic        done_q;
    logic        err_q;
    logic        overflow_q;
    logic [15:0] count_q;

    logic [31:0] enc_word;
    logic        enc_legal;
    logic        accept;
    logic [15:0] count_inc;
    logic        cap_hit;

    always_comb begin
        enc_word  = 32'h0;
        enc_legal = 1'b1;
        case (bus.op_sel)
            OP_ADD:  enc_word = {6'b000000, bus.rs, bus.rt, bus.rd, 5'b0, F_ADD};
            OP_SUB:  enc_word = {6'b000000, bus.rs, bus.rt, bus.rd, 5'b0, F_SUB};
            OP_AND:  enc_word = {6'b000000, bus.rs, bus.rt, bus.rd, 5'b0, F_AND};
            OP_OR:   enc_word = {6'b000000, bus.rs, bus.rt, bus.rd, 5'b0, F_OR};
            OP_SLT:  enc_word = {6'b000000, bus.rs, bus.rt, bus.rd, 5'b0, F_SLT};
            OP_LW:   enc_word = {OPC_LW,   bus.rs, bus.rt, bus.imm};
            OP_SW:   enc_word = {OPC_SW,   bus.rs, bus.rt, bus.imm};
            OP_BEQ:  enc_word = {OPC_BEQ,  bus.rs, bus.rt, bus.imm};
            OP_ADDI: enc_word = {OPC_ADDI, bus.rs, bus.rt, bus.imm};
            OP_SLTI: enc_word = {OPC_SLTI, bus.rs, bus.rt, bus.imm};
            OP_J:    enc_word = {OPC_J,   bus.target};
            OP_JAL:  enc_word = {OPC_JAL, bus.target};
            OP_JR:   enc_word = {OPC_JR, bus.rs, 21'b0};
            default: enc_legal = 1'b0;
        endcase
    end

    assign accept    = bus.in_valid && (state == S_LOAD);
    assign count_inc = count_q + 16'd1;
    // Only a written word counts toward capacity; illegal words never end a load on size.
    assign cap_hit   = enc_legal && (count_inc == MAX_CNT);

    always_ff @(posedge clk) begin
        if (rst) begin
            state       <= S_IDLE;
            wptr        <= BASE_ADDR;
            mem_we_q    <= 1'b0;
            mem_addr_q  <= BASE_ADDR;
            mem_wdata_q <= 32'h0;
            cpu_hold_q  <= 1'b1;
            done_q      <= 1'b0;
            err_q       <= 1'b0;
            overflow_q  <= 1'b0;
            count_q     <= 16'd0;
        end else begin
            mem_we_q <= 1'b0;
            case (state)
                S_IDLE, S_DONE: begin
                    // Release is one edge after entering DONE so the final write lands first.
                    if (state == S_DONE) begin
                        done_q     <= 1'b1;
                        cpu_hold_q <= 1'b0;
                    end
                    if (start) begin
                        state      <= S_LOAD;
                        wptr       <= BASE_ADDR;
                        count_q    <= 16'd0;
                        err_q      <= 1'b0;
                        overflow_q <= 1'b0;
                        cpu_hold_q <= 1'b1;
                        done_q     <= 1'b0;
                    end
                end
                S_LOAD: begin
                    if (accept) begin
                        if (enc_legal) begin
                            mem_we_q    <= 1'b1;
                            mem_addr_q  <= wptr;
                            mem_wdata_q <= enc_word;
                            wptr        <= wptr + 32'd4;
                            count_q     <= count_inc;
                        end else begin
                            err_q <= 1'b1;
                        end
                        if (bus.in_last || cap_hit) begin
                            state <= S_DONE;
                            if (!bus.in_last) begin
                                overflow_q <= 1'b1;
                            end
                        end
                    end
                end
                default: state <= S_IDLE;
            endcase
        end
    end

    assign bus.in_ready  = (state == S_LOAD);
    assign bus.mem_we    = mem_we_q;
    assign bus.mem_addr  = mem_addr_q;
    assign bus.mem_wdata = mem_wdata_q;
    assign cpu_hold      = cpu_hold_q;
    assign done          = done_q;
    assign err           = err_q;
    assign overflow      = overflow_q;
    assign word_count    = count_q;
    assign state_dbg     = state;

endmodule

// File: tb/tb_instr_mem_loader.sv
// Directed bench for instr_mem_loader (BASE_ADDR=0, MAX_WORDS=4): writes are scored
// against an expected {addr,data} queue; status outputs are checked at each step.
module tb_instr_mem_loader;
  logic        clk;
  logic        rst;
  logic        start;
  logic        cpu_hold;
  logic        done;
  logic        err;
  logic        overflow;
  logic [15:0] word_count;
  logic [1:0]  state_dbg;

  int total;
  int bad;
  logic [63:0] exp_q[$];

  instr_mem_loader_if bus ();

  instr_mem_loader #(
    .BASE_ADDR (32'h0000_0000),
    .MAX_WORDS (4)
  ) dut (
    .clk        (clk),
    .rst        (rst),
    .start      (start),
    .bus        (bus.slave),
    .cpu_hold   (cpu_hold),
    .done       (done),
    .err        (err),
    .overflow   (overflow),
    .word_count (word_count),
    .state_dbg  (state_dbg)
  );

  // clock / reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // scoreboard: every write strobe must match the head of exp_q
  always @(negedge clk) begin
    if (bus.mem_we === 1'b1) begin
      if (exp_q.size() == 0) begin
        total++;
        assert (exp_q.size() != 0) else begin
          bad++;
          $error("FAIL wr_unexpected observed=%h expected=none", {bus.mem_addr, bus.mem_wdata});
        end
      end else begin
        chk("wr", {bus.mem_addr, bus.mem_wdata}, exp_q.pop_front());
      end
    end
  end

  // drivers: each is entered and left at a falling edge
  task automatic do_start();
    start = 1'b1;
    @(posedge clk);
    @(negedge clk);
    start = 1'b0;
    chk("start_ready", 64'(bus.in_ready), 64'd1);
    chk("start_hold", 64'(cpu_hold), 64'd1);
    chk("start_done", 64'(done), 64'd0);
    chk("start_cnt", 64'(word_count), 64'd0);
    chk("start_err", 64'(err), 64'd0);
    chk("start_ovf", 64'(overflow), 64'd0);
    chk("start_state", 64'(state_dbg), 64'd1);
  endtask

  task automatic send(input logic [3:0] op, input logic [4:0] rs, input logic [4:0] rt,
                      input logic [4:0] rd, input logic [15:0] imm, input logic [25:0] tgt,
                      input logic last, input logic exp_ready);
    bus.in_valid = 1'b1;
    bus.op_sel   = op;
    bus.rs       = rs;
    bus.rt       = rt;
    bus.rd       = rd;
    bus.imm      = imm;
    bus.target   = tgt;
    bus.in_last  = last;
    chk("in_ready", 64'(bus.in_ready), 64'(exp_ready));
    @(posedge clk);
    @(negedge clk);
    bus.in_valid = 1'b0;
    bus.in_last  = 1'b0;
  endtask

  task automatic wait_done();
    for (int i = 0; i < 10 && done !== 1'b1; i++) @(negedge clk);
    chk("done_wait", 64'(done), 64'd1);
  endtask

  initial begin
    total = 0;
    bad   = 0;
    rst   = 1'b1;
    start = 1'b0;
    bus.in_valid = 1'b0;
    bus.in_last  = 1'b0;
    bus.op_sel   = 4'd0;
    bus.rs       = 5'd0;
    bus.rt       = 5'd0;
    bus.rd       = 5'd0;
    bus.imm      = 16'd0;
    bus.target   = 26'd0;
    repeat (3) @(posedge clk);
    @(negedge clk);

    // reset state
    chk("rst_ready", 64'(bus.in_ready), 64'd0);
    chk("rst_we", 64'(bus.mem_we), 64'd0);
    chk("rst_addr", 64'(bus.mem_addr), 64'd0);
    chk("rst_wdata", 64'(bus.mem_wdata), 64'd0);
    chk("rst_hold", 64'(cpu_hold), 64'd1);
    chk("rst_done", 64'(done), 64'd0);
    chk("rst_err", 64'(err), 64'd0);
    chk("rst_ovf", 64'(overflow), 64'd0);
    chk("rst_cnt", 64'(word_count), 64'd0);
    chk("rst_state", 64'(state_dbg), 64'd0);
    rst = 1'b0;
    @(negedge clk);
    chk("idle_ready", 64'(bus.in_ready), 64'd0);

    // ADD then LW with in_last; exact release timing
    do_start();
    exp_q.push_back({32'h0, 32'h0022_1820});
    exp_q.push_back({32'h4, 32'h8FA8_0004});
    send(4'd0, 5'd1, 5'd2, 5'd3, 16'hBEEF, 26'h155, 1'b0, 1'b1);
    send(4'd5, 5'd29, 5'd8, 5'd17, 16'h0004, 26'h3FF, 1'b1, 1'b1);
    chk("t1_we_last", 64'(bus.mem_we), 64'd1);
    chk("t1_ready_off", 64'(bus.in_ready), 64'd0);
    chk("t1_done_early", 64'(done), 64'd0);
    chk("t1_hold_early", 64'(cpu_hold), 64'd1);
    chk("t1_cnt", 64'(word_count), 64'd2);
    @(negedge clk);
    chk("t1_done", 64'(done), 64'd1);
    chk("t1_hold", 64'(cpu_hold), 64'd0);
    chk("t1_we_after", 64'(bus.mem_we), 64'd0);
    chk("t1_state", 64'(state_dbg), 64'd2);

    // BEQ, SLTI, JR with stray fields, J: four words hits capacity exactly with in_last
    do_start();
    exp_q.push_back({32'h0, 32'h1022_FFFF});
    exp_q.push_back({32'h4, 32'h2885_0007});
    exp_q.push_back({32'h8, 32'h1BE0_0000});
    exp_q.push_back({32'hC, 32'h0800_0010});
    send(4'd7, 5'd1, 5'd2, 5'd31, 16'hFFFF, 26'h2AAAAAA, 1'b0, 1'b1);
    send(4'd12, 5'd4, 5'd5, 5'd9, 16'h0007, 26'h1234, 1'b0, 1'b1);
    chk("t2_we_b2b", 64'(bus.mem_we), 64'd1);
    send(4'd11, 5'd31, 5'd7, 5'd9, 16'hAAAA, 26'h3FFFFFF, 1'b0, 1'b1);
    send(4'd9, 5'd5, 5'd6, 5'd7, 16'h8888, 26'h10, 1'b1, 1'b1);
    wait_done();
    chk("t2_cnt", 64'(word_count), 64'd4);
    chk("t2_ovf", 64'(overflow), 64'd0);

    // illegal op between two ADDs
    do_start();
    exp_q.push_back({32'h0, 32'h0022_1820});
    exp_q.push_back({32'h4, 32'h0022_1820});
    send(4'd0, 5'd1, 5'd2, 5'd3, 16'h0, 26'h0, 1'b0, 1'b1);
    send(4'd14, 5'd1, 5'd2, 5'd3, 16'h0, 26'h0, 1'b0, 1'b1);
    chk("t3_err_set", 64'(err), 64'd1);
    chk("t3_cnt_mid", 64'(word_count), 64'd1);
    send(4'd0, 5'd1, 5'd2, 5'd3, 16'h0, 26'h0, 1'b1, 1'b1);
    wait_done();
    chk("t3_err_done", 64'(err), 64'd1);
    chk("t3_cnt", 64'(word_count), 64'd2);

    // six words, no in_last: capacity stops the load at four
    do_start();
    chk("t4_err_clr", 64'(err), 64'd0);
    exp_q.push_back({32'h0, 32'h00A6_2023});
    exp_q.push_back({32'h4, 32'h0021_0824});
    exp_q.push_back({32'h8, 32'hAC43_0010});
    exp_q.push_back({32'hC, 32'h2407_1234});
    send(4'd1, 5'd5, 5'd6, 5'd4, 16'h0, 26'h0, 1'b0, 1'b1);
    send(4'd2, 5'd1, 5'd1, 5'd1, 16'h0, 26'h0, 1'b0, 1'b1);
    send(4'd6, 5'd2, 5'd3, 5'd0, 16'h0010, 26'h0, 1'b0, 1'b1);
    send(4'd8, 5'd0, 5'd7, 5'd0, 16'h1234, 26'h0, 1'b0, 1'b1);
    chk("t4_ovf_early", 64'(overflow), 64'd1);
    send(4'd3, 5'd8, 5'd9, 5'd7, 16'h0, 26'h0, 1'b0, 1'b0);
    send(4'd4, 5'd3, 5'd4, 5'd2, 16'h0, 26'h0, 1'b0, 1'b0);
    wait_done();
    chk("t4_ovf", 64'(overflow), 64'd1);
    chk("t4_ready", 64'(bus.in_ready), 64'd0);
    chk("t4_cnt", 64'(word_count), 64'd4);

    // start from DONE clears flags and restarts at BASE_ADDR
    do_start();
    exp_q.push_back({32'h0, 32'h0FFF_FFFF});
    send(4'd10, 5'd1, 5'd2, 5'd3, 16'h5555, 26'h3FFFFFF, 1'b1, 1'b1);
    wait_done();
    chk("t6_cnt", 64'(word_count), 64'd1);
    chk("t6_ovf", 64'(overflow), 64'd0);

    // reset mid-load, then a fresh single-word load
    do_start();
    exp_q.push_back({32'h0, 32'h0109_3825});
    exp_q.push_back({32'h4, 32'h0064_102A});
    send(4'd3, 5'd8, 5'd9, 5'd7, 16'h0, 26'h0, 1'b0, 1'b1);
    send(4'd4, 5'd3, 5'd4, 5'd2, 16'h0, 26'h0, 1'b0, 1'b1);
    rst = 1'b1;
    @(posedge clk);
    @(negedge clk);
    rst = 1'b0;
    chk("t5_state", 64'(state_dbg), 64'd0);
    chk("t5_hold", 64'(cpu_hold), 64'd1);
    chk("t5_ready", 64'(bus.in_ready), 64'd0);
    chk("t5_cnt_rst", 64'(word_count), 64'd0);
    chk("t5_we_rst", 64'(bus.mem_we), 64'd0);
    @(negedge clk);
    do_start();
    exp_q.push_back({32'h0, 32'h0064_102A});
    send(4'd4, 5'd3, 5'd4, 5'd2, 16'h0, 26'h0, 1'b1, 1'b1);
    wait_done();
    chk("t5_cnt", 64'(word_count), 64'd1);

    repeat (2) @(negedge clk);
    chk("pending_writes", 64'(exp_q.size()), 64'd0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
